decoder_rr_arbiter_16: RTL and testbench

//  Round-robin arbiter that shares one 16-way one-hot select resource between 16 requesters.

---
 rtl/decoder_rr_arbiter_16.sv | 100 ++++++++++
 tb/tb_decoder_rr_arbiter_16.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/decoder_rr_arbiter_16.sv
// decoder_rr_arbiter_16: round-robin arbiter owning a 4-to-16 one-hot select decoder.
// Define DECODER_RR_ARB_TIMEOUT_EN to add forced rotation after MAX_HOLD grant cycles.
module decoder_4_to_16 (
    input  logic        ena_i,
    input  logic [3:0]  in_i,
    output logic [15:0] out_o
);
    assign out_o = ena_i ? 16'd1 << in_i : 16'd0;
endmodule

module decoder_rr_arbiter_16 #(
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena_i,
    input  logic [15:0] req_i,
    output logic [15:0] grant_o,
    output logic [3:0]  grant_idx_o,
    output logic        grant_valid_o,
    output logic        preempt_o
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t      state_q;
    logic [3:0]  idx_q;
    logic [3:0]  ptr_q;
    logic [15:0] cand;
    logic [3:0]  win;
    logic        found;
    logic        rel;
    logic        take;
    logic        tmo;

    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("MAX_HOLD must be at least 1");
    end

    // The releasing owner is masked so it cannot immediately win again.
    always_comb begin
        cand  = (state_q == GRANT) ? req_i & ~(16'd1 << idx_q) : req_i;
        win   = 4'd0;
        found = 1'b0;
        for (int k = 0; k < 16; k++)
            if (!found && cand[ptr_q + 4'(k)]) begin
                win   = ptr_q + 4'(k);
                found = 1'b1;
            end
    end

    assign rel  = (state_q == GRANT) && !req_i[idx_q];
    assign take = ena_i && found;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            ptr_q   <= 4'd0;
        end else if (take && (state_q == IDLE || rel || tmo)) begin
            state_q <= GRANT;
            idx_q   <= win;
            ptr_q   <= win + 4'd1;
        end else if (rel) begin
            state_q <= IDLE;
        end

`ifdef DECODER_RR_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] hold_q;
    logic              preempt_q;

    assign tmo = (state_q == GRANT) && !rel && (hold_q == HOLD_W'(MAX_HOLD - 1));

    // Without a waiting rival the counter saturates and the grant is kept.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            preempt_q <= tmo && take;
            if (state_q == IDLE || rel || (tmo && take))
                hold_q <= '0;
            else if (!tmo)
                hold_q <= hold_q + 1'b1;
        end

    assign preempt_o = preempt_q;
`else
    assign tmo       = 1'b0;
    assign preempt_o = 1'b0;
`endif

    assign grant_valid_o = (state_q == GRANT);
    assign grant_idx_o   = idx_q;

    decoder_4_to_16 u_dec (
        .ena_i (grant_valid_o),
        .in_i  (idx_q),
        .out_o (grant_o)
    );
endmodule

// File: tb/tb_decoder_rr_arbiter_16.sv
// tb_decoder_rr_arbiter_16: directed bench with a cycle-level ownership model.
// Honors DECODER_RR_ARB_TIMEOUT_EN to select the expected timeout behaviour.
module tb_decoder_rr_arbiter_16;
    localparam int MAX_HOLD = 8;
`ifdef DECODER_RR_ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic [15:0] req = 16'd0;
    logic [15:0] grant;
    logic [3:0]  grant_idx;
    logic        grant_valid;
    logic        preempt;

    int checks = 0;
    int errors = 0;

    int m_valid, m_idx, m_ptr, m_hold, m_pre;
    int w;
    bit rel, tmo;

    decoder_rr_arbiter_16 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena_i         (ena),
        .req_i         (req),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid),
        .preempt_o     (preempt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [15:0] r, input int ptr, input int excl);
        for (int k = 0; k < 16; k++)
            if (r[(ptr + k) % 16] && ((ptr + k) % 16) != excl) return (ptr + k) % 16;
        return -1;
    endfunction

    // Ownership model: who holds the resource, whose turn is next, how long held.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0; m_idx = 0; m_ptr = 0; m_hold = 0; m_pre = 0;
        end else begin
            m_pre = 0;
            rel = (m_valid != 0) && !req[m_idx];
            tmo = TMO && (m_valid != 0) && !rel && (m_hold == MAX_HOLD - 1);
            if (m_valid == 0 || rel || tmo) begin
                w = pick(req, m_ptr, m_valid != 0 ? m_idx : -1);
                if (ena && w >= 0) begin
                    m_pre = tmo ? 1 : 0;
                    m_valid = 1; m_idx = w; m_ptr = (w + 1) % 16; m_hold = 0;
                end else if (rel) begin
                    m_valid = 0; m_hold = 0;
                end
            end else begin
                m_hold++;
            end
        end
    end

    always @(negedge clk) begin
        chk("grant", grant, m_valid != 0 ? 16'd1 << m_idx : 16'd0);
        chk("grant_valid", grant_valid, m_valid);
        if (m_valid != 0) chk("grant_idx", grant_idx, m_idx);
        chk("preempt", preempt, m_pre);
        chk("onehot0", $onehot0(grant), 1);
        chk("grant_at_idx", grant[grant_idx], grant_valid);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = 16'd0; ena = 1'b0; rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        do_reset();
        // reset mid-grant drops everything at once
        ena = 1'b1; req = 16'h0010;
        step(1);
        chk("t1_grant", grant, 16'h0010);
        rst_n = 1'b0;
        #1;
        chk("t1_rst_grant", grant, 16'h0000);
        chk("t1_rst_valid", grant_valid, 0);
        chk("t1_rst_idx", grant_idx, 0);
        req = 16'd0;
        step(1);
        rst_n = 1'b1;
        step(1);
        // full round robin with one-cycle tenures
        ena = 1'b1; req = 16'hFFFF;
        step(1);
        for (int k = 0; k < 17; k++) begin
            chk("t3_idx", grant_idx, k % 16);
            chk("t3_valid", grant_valid, 1);
            req = 16'hFFFF & ~(16'd1 << (k % 16));
            step(1);
        end
        req = 16'd0;
        step(1);
        chk("t3_idle", grant_valid, 0);
        // single requester latency
        req = 16'h0008;
        step(1);
        chk("t2_grant", grant, 16'h0008);
        chk("t2_idx", grant_idx, 3);
        req = 16'd0;
        step(1);
        chk("t2_drop", grant, 16'h0000);
        // wrap from pointer 15
        req = 16'h4000;
        step(1);
        chk("t4_idx14", grant_idx, 14);
        req = 16'h8001;
        step(1);
        chk("t4_idx15", grant_idx, 15);
        req = 16'h0001;
        step(1);
        chk("t4_idx0", grant_idx, 0);
        req = 16'd0;
        step(1);
        chk("t4_idle", grant_valid, 0);
        // enable gating
        ena = 1'b0; req = 16'h0100;
        step(3);
        chk("t5_blocked", grant, 16'h0000);
        ena = 1'b1;
        step(1);
        chk("t5_grant", grant, 16'h0100);
        ena = 1'b0; req = 16'h0101;
        step(2);
        chk("t5_keep", grant, 16'h0100);
        req = 16'h0001;
        step(1);
        chk("t5_idle", grant_valid, 0);
        step(1);
        chk("t5_still_idle", grant, 16'h0000);
        ena = 1'b1;
        step(1);
        chk("t5_resume", grant, 16'h0001);
        req = 16'd0;
        step(1);
        // hold behaviour with two persistent requesters
        do_reset();
        ena = 1'b1; req = 16'h0003;
        step(1);
        if (TMO) begin
            for (int p = 0; p < 3; p++)
                for (int c = 0; c < MAX_HOLD; c++) begin
                    chk("t6_idx", grant_idx, p % 2);
                    chk("t6_preempt", preempt, (c == 0 && p > 0) ? 1 : 0);
                    step(1);
                end
        end else begin
            for (int c = 0; c < 20; c++) begin
                chk("t6_hold_idx", grant_idx, 0);
                chk("t6_no_preempt", preempt, 0);
                step(1);
            end
        end
        req = 16'd0;
        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
